// File: rtl/anffl_tex_color_packer.sv
// Packs a stream of RGBA8 pixels into 128-bit texture words in one of nine fixed formats.
// Each word is presented with per-byte enables and a flag marking the final word of a run.
module anffl_tex_color_packer (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [4:0]   fmt,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_r,
    input  logic [7:0]   in_g,
    input  logic [7:0]   in_b,
    input  logic [7:0]   in_a,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic [15:0]  out_mask,
    output logic         out_last,
    output logic         busy,
    output logic         err
);

    typedef enum logic [1:0] {IDLE, FILL, EMIT} state_t;
    typedef enum logic [1:0] {K_NONE, K_32, K_16, K_8} kind_t;

    function automatic kind_t fmt_kind(input logic [4:0] f);
        case (f)
            5'b00100, 5'b00111:                         return K_32;
            5'b00001, 5'b00101, 5'b01001, 5'b01101,
            5'b01011, 5'b01111:                         return K_16;
            5'b10011:                                   return K_8;
            default:                                    return K_NONE;
        endcase
    endfunction

    // Tiled 16-bit codes share the encoding of their linear counterparts.
    function automatic logic [15:0] enc16(input logic [4:0] f, input logic [7:0] r,
                                          input logic [7:0] g, input logic [7:0] b,
                                          input logic [7:0] a);
        case (f)
            5'b00001, 5'b01011: return {b[7:3], g[7:2], r[7:3]};
            5'b00101, 5'b01111: return {a[7:4], b[7:4], g[7:4], r[7:4]};
            5'b01001:           return {1'b0, b[7:3], g[7:3], r[7:3]};
            5'b01101:           return {a[7], b[7:3], g[7:3], r[7:3]};
            default:            return 16'h0000;
        endcase
    endfunction

    state_t         state_q, state_d;
    logic [4:0]     fmt_q, fmt_d;
    logic [3:0]     slot_q, slot_d;
    logic [127:0]   word_q, word_d;
    logic [15:0]    mask_q, mask_d;
    logic           last_q, last_d;
    logic           err_q, err_d;
    kind_t          kind_q;
    logic           word_full;

    assign kind_q = fmt_kind(fmt_q);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d   = state_q;
        fmt_d     = fmt_q;
        slot_d    = slot_q;
        word_d    = word_q;
        mask_d    = mask_q;
        last_d    = last_q;
        err_d     = 1'b0;
        word_full = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (fmt_kind(fmt) != K_NONE) begin
                        fmt_d   = fmt;
                        slot_d  = 4'd0;
                        word_d  = '0;
                        mask_d  = '0;
                        last_d  = 1'b0;
                        state_d = FILL;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            FILL: begin
                if (in_valid) begin
                    case (kind_q)
                        K_32: begin
                            word_d[{slot_q[1:0], 5'b00000} +: 32] = {in_a, in_b, in_g, in_r};
                            mask_d[{slot_q[1:0], 2'b00} +: 4]     = 4'hF;
                            word_full = (slot_q[1:0] == 2'd3);
                        end
                        K_16: begin
                            word_d[{slot_q[2:0], 4'b0000} +: 16] = enc16(fmt_q, in_r, in_g, in_b, in_a);
                            mask_d[{slot_q[2:0], 1'b0} +: 2]     = 2'b11;
                            word_full = (slot_q[2:0] == 3'd7);
                        end
                        K_8: begin
                            word_d[{slot_q, 3'b000} +: 8] = in_r;
                            mask_d[slot_q]                = 1'b1;
                            word_full = (slot_q == 4'd15);
                        end
                        default: ;
                    endcase
                    slot_d = slot_q + 4'd1;
                    if (word_full || in_last) begin
                        last_d  = in_last;
                        state_d = EMIT;
                    end
                end
            end

            EMIT: begin
                if (out_ready) begin
                    last_d = 1'b0;
                    if (last_q) begin
                        state_d = IDLE;
                    end else begin
                        slot_d  = 4'd0;
                        word_d  = '0;
                        mask_d  = '0;
                        state_d = FILL;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            fmt_q   <= 5'd0;
            slot_q  <= 4'd0;
            word_q  <= '0;
            mask_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fmt_q   <= fmt_d;
            slot_q  <= slot_d;
            word_q  <= word_d;
            mask_q  <= mask_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == EMIT);
    assign out_data  = word_q;
    assign out_mask  = mask_q;
    assign out_last  = last_q;
    assign busy      = (state_q != IDLE);
    assign err       = err_q;

endmodule
